// File: rtl/phase_diff_decim.sv
// Phase discriminator back end. It forms the wrapped difference between
// consecutive angle samples, averages 2^DEC_LOG2 of these differences, and
// presents each average through a valid/ready output register.
module phase_diff_decim #(
  parameter int                 DEC_LOG2 = 3,
  parameter logic signed [15:0] PI_VAL   = 16'sd25736
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               val_i,
  input  logic signed [15:0] angle_i,
  output logic signed [15:0] freq_o,
  output logic               val_o,
  input  logic               rdy_i,
  output logic               ovf_o
);

  localparam int AW    = 16 + DEC_LOG2;
  localparam int DEC_N = 1 << DEC_LOG2;
  localparam logic [DEC_LOG2-1:0] CNT_MAX = DEC_LOG2'(DEC_N - 1);
  localparam logic [DEC_LOG2-1:0] CNT_ONE = DEC_LOG2'(1);

  localparam logic signed [16:0] PI17     = {PI_VAL[15], PI_VAL};
  localparam logic signed [16:0] TWO_PI17 = PI17 <<< 1;

  logic signed [15:0]   prev_angle_q, prev_angle_d;
  logic                 prev_valid_q, prev_valid_d;
  logic signed [15:0]   diff_q, diff_d;
  logic                 diff_val_q, diff_val_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DEC_LOG2-1:0]  cnt_q, cnt_d;
  logic signed [15:0]   freq_q, freq_d;
  logic                 val_q, val_d;
  logic                 ovf_q, ovf_d;

  logic signed [16:0]   d_raw, d_wrap;
  logic signed [AW-1:0] sum, sum_shift;
  logic                 unused_bits;

  // Stage 1: wrapped phase difference of consecutive valid samples.
  always_comb begin
    prev_angle_d = prev_angle_q;
    prev_valid_d = prev_valid_q;
    diff_d       = diff_q;
    diff_val_d   = 1'b0;
    d_raw        = {angle_i[15], angle_i} - {prev_angle_q[15], prev_angle_q};
    d_wrap       = d_raw;
    if (d_raw > PI17) begin
      d_wrap = d_raw - TWO_PI17;
    end else if (d_raw < -PI17) begin
      d_wrap = d_raw + TWO_PI17;
    end
    if (val_i) begin
      prev_angle_d = angle_i;
      prev_valid_d = 1'b1;
      if (prev_valid_q) begin
        diff_d     = d_wrap[15:0];
        diff_val_d = 1'b1;
      end
    end
  end

  // Stage 2: accumulate differences, emit the average, run the output handshake.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    freq_d    = freq_q;
    val_d     = val_q;
    ovf_d     = ovf_q;
    sum       = acc_q + {{DEC_LOG2{diff_q[15]}}, diff_q};
    sum_shift = sum >>> DEC_LOG2;
    if (val_q && rdy_i) begin
      val_d = 1'b0;
    end
    if (diff_val_q) begin
      if (cnt_q == CNT_MAX) begin
        freq_d = sum_shift[15:0];
        acc_d  = '0;
        cnt_d  = '0;
        val_d  = 1'b1;
        // Overwriting a result nobody took is remembered until reset.
        if (val_q && !rdy_i) begin
          ovf_d = 1'b1;
        end
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  assign unused_bits = ^{d_wrap[16], sum_shift[AW-1:16]};

  // State registers with synchronous reset; partial accumulations are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_angle_q <= '0;
      prev_valid_q <= 1'b0;
      diff_q       <= '0;
      diff_val_q   <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      freq_q       <= '0;
      val_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      prev_angle_q <= prev_angle_d;
      prev_valid_q <= prev_valid_d;
      diff_q       <= diff_d;
      diff_val_q   <= diff_val_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      freq_q       <= freq_d;
      val_q        <= val_d;
      ovf_q        <= ovf_d;
    end
  end

  assign freq_o = freq_q;
  assign val_o  = val_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_phase_diff_decim.sv
// Directed bench for phase_diff_decim (DEC_LOG2=3, PI_VAL=25736).
module tb_phase_diff_decim;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               val_i = 1'b0;
  logic signed [15:0] angle_i = '0;
  logic signed [15:0] freq_o;
  logic               val_o;
  logic               rdy_i = 1'b1;
  logic               ovf_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic signed [15:0] out_q[$];
  int                 out_cyc[$];

  phase_diff_decim dut (
    .clk     (clk),
    .rst     (rst),
    .val_i   (val_i),
    .angle_i (angle_i),
    .freq_o  (freq_o),
    .val_o   (val_o),
    .rdy_i   (rdy_i),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output with the cycle it was taken.
  always @(negedge clk) begin
    if (!rst && val_o && rdy_i) begin
      out_q.push_back(freq_o);
      out_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a);
    val_i   = 1'b1;
    angle_i = 16'(a);
    tick();
  endtask

  task automatic idle(input int n);
    val_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    val_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic int wrapang(input int a);
    int m;
    m = a % 51472;
    if (m > 25736) m = m - 51472;
    return m;
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (freq_o !== 16'sd0) begin bad++; $display("FAIL reset_freq got=%0d exp=0", freq_o); end
    total++; if (val_o !== 1'b0) begin bad++; $display("FAIL reset_val got=%b exp=0", val_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
  endtask

  task automatic test_constant();
    do_reset();
    rdy_i = 1'b1;
    out_q.delete(); out_cyc.delete();
    for (int i = 0; i < 33; i++) send(5000);
    idle(3);
    total++; if (out_q.size() !== 4) begin bad++; $display("FAIL const_count got=%0d exp=4", out_q.size()); end
    foreach (out_q[i]) begin
      total++; if (out_q[i] !== 16'sd0) begin bad++; $display("FAIL const_val[%0d] got=%0d exp=0", i, out_q[i]); end
    end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL const_ovf got=%b exp=0", ovf_o); end
  endtask

  task automatic test_ramp();
    do_reset();
    rdy_i = 1'b1;
    out_q.delete(); out_cyc.delete();
    for (int k = 0; k < 49; k++) begin
      send(wrapang(k * 1000));
      if (k == 8) begin
        total++; if (val_o !== 1'b0) begin bad++; $display("FAIL ramp_lat_early got=%b exp=0", val_o); end
      end
      if (k == 9) begin
        total++; if (val_o !== 1'b1) begin bad++; $display("FAIL ramp_lat got=%b exp=1", val_o); end
      end
    end
    idle(3);
    total++; if (out_q.size() !== 6) begin bad++; $display("FAIL ramp_count got=%0d exp=6", out_q.size()); end
    foreach (out_q[i]) begin
      total++; if (out_q[i] !== 16'sd1000) begin bad++; $display("FAIL ramp_val[%0d] got=%0d exp=1000", i, out_q[i]); end
      if (i > 0) begin
        total++; if (out_cyc[i] - out_cyc[i-1] !== 8) begin bad++; $display("FAIL ramp_spacing[%0d] got=%0d exp=8", i, out_cyc[i] - out_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_irregular();
    do_reset();
    rdy_i = 1'b1;
    out_q.delete(); out_cyc.delete();
    for (int k = 0; k < 49; k++) begin
      send(wrapang(k * 1000));
      idle(2);
    end
    idle(3);
    total++; if (out_q.size() !== 6) begin bad++; $display("FAIL irreg_count got=%0d exp=6", out_q.size()); end
    foreach (out_q[i]) begin
      total++; if (out_q[i] !== 16'sd1000) begin bad++; $display("FAIL irreg_val[%0d] got=%0d exp=1000", i, out_q[i]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rdy_i = 1'b1;
    out_q.delete(); out_cyc.delete();
    send(25000);
    for (int j = 0; j < 8; j++) send(-25000 + 1472 * j);
    idle(3);
    total++; if (out_q.size() !== 1) begin bad++; $display("FAIL wrap_pos_count got=%0d exp=1", out_q.size()); end
    if (out_q.size() > 0) begin
      total++; if (out_q[0] !== 16'sd1472) begin bad++; $display("FAIL wrap_pos got=%0d exp=1472", out_q[0]); end
    end
    do_reset();
    out_q.delete(); out_cyc.delete();
    send(-25000);
    for (int j = 0; j < 8; j++) send(25000 - 1472 * j);
    idle(3);
    total++; if (out_q.size() !== 1) begin bad++; $display("FAIL wrap_neg_count got=%0d exp=1", out_q.size()); end
    if (out_q.size() > 0) begin
      total++; if (out_q[0] !== -16'sd1472) begin bad++; $display("FAIL wrap_neg got=%0d exp=-1472", out_q[0]); end
    end
  endtask

  task automatic test_neg_trunc();
    do_reset();
    rdy_i = 1'b1;
    out_q.delete(); out_cyc.delete();
    for (int j = 0; j < 8; j++) send(-j);
    send(-7);
    idle(3);
    total++; if (out_q.size() !== 1) begin bad++; $display("FAIL trunc_count got=%0d exp=1", out_q.size()); end
    if (out_q.size() > 0) begin
      total++; if (out_q[0] !== -16'sd1) begin bad++; $display("FAIL trunc_val got=%0d exp=-1", out_q[0]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_i = 1'b0;
    for (int j = 0; j <= 8; j++) send(100 * j);
    idle(2);
    total++; if (val_o !== 1'b1) begin bad++; $display("FAIL bp1_val got=%b exp=1", val_o); end
    total++; if (freq_o !== 16'sd100) begin bad++; $display("FAIL bp1_freq got=%0d exp=100", freq_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL bp1_ovf got=%b exp=0", ovf_o); end
    for (int j = 1; j <= 8; j++) send(800 + 200 * j);
    idle(2);
    total++; if (freq_o !== 16'sd200) begin bad++; $display("FAIL bp2_freq got=%0d exp=200", freq_o); end
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL bp2_ovf got=%b exp=1", ovf_o); end
    for (int j = 1; j <= 8; j++) send(2400 + 300 * j);
    idle(2);
    total++; if (freq_o !== 16'sd300) begin bad++; $display("FAIL bp3_freq got=%0d exp=300", freq_o); end
    total++; if (val_o !== 1'b1) begin bad++; $display("FAIL bp3_val got=%b exp=1", val_o); end
    rdy_i = 1'b1;
    tick();
    rdy_i = 1'b0;
    total++; if (val_o !== 1'b0) begin bad++; $display("FAIL bp_drain_val got=%b exp=0", val_o); end
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL bp_drain_ovf got=%b exp=1", ovf_o); end
  endtask

  // Runs straight after backpressure so the sticky overflow is still set.
  task automatic test_mid_reset();
    rdy_i = 1'b1;
    for (int j = 0; j < 5; j++) send(3000 * j);
    do_reset();
    total++; if (val_o !== 1'b0) begin bad++; $display("FAIL mrst_val got=%b exp=0", val_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL mrst_ovf got=%b exp=0", ovf_o); end
    out_q.delete(); out_cyc.delete();
    for (int k = 0; k < 8; k++) send(wrapang(20000 + 1000 * k));
    idle(2);
    total++; if (out_q.size() !== 0) begin bad++; $display("FAIL mrst_early got=%0d outputs exp=0", out_q.size()); end
    send(wrapang(28000));
    idle(2);
    total++; if (out_q.size() !== 1) begin bad++; $display("FAIL mrst_count got=%0d exp=1", out_q.size()); end
    if (out_q.size() > 0) begin
      total++; if (out_q[0] !== 16'sd1000) begin bad++; $display("FAIL mrst_val got=%0d exp=1000", out_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_irregular();
    test_wrap();
    test_neg_trunc();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
